fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front-end that sits directly upstream of the pipelined core's decode register. It issues sequential word fetches to an instruction memory port with a request/response handshake and buffers the returned instructions with their PCs in a small FIFO. It presents them to decode under a valid/ready handshake, and flushes and restarts fetching at a new PC when execute signals a taken branch or jump.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- redirect  in  1  taken branch/jump from execute (br_taken).
- redirect_pc  in  32  target address (ALUResultE); bits [1:0] ignored, treated as 0.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch word address, always 4-aligned.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response valid; exactly one per accepted request, in order, ≥1 cycle after acceptance.
- mem_rdata  in  32  response instruction.
- instr_valid  out  1  queue head valid.
- instr  out  32  head instruction; 32'h0 when instr_valid=0.
- instr_pc  out  32  head PC; 32'h0 when instr_valid=0.
- decode_ready  in  1  decode consumes head this cycle (!StallD).

## Operation
- Registers: fetch_pc, FIFO storage (DEPTH × {pc, instr}), read/write pointers, count (0..DEPTH), 2-bit state.
- States:
  - IDLE: no outstanding request.
  - WAIT: one outstanding request whose response is kept.
  - DISCARD: one outstanding request whose response is dropped.
- At most one request outstanding. The credit condition is count + (state==WAIT) < DEPTH.
- mem_req = credit && (state==IDLE || mem_rvalid). mem_req is combinational, allowing a back-to-back issue on the response cycle. mem_addr = fetch_pc.
- Accept (mem_req && mem_ready): fetch_pc += 4 (wraps modulo 2^32).
  - Next state is WAIT, or DISCARD if redirect is high in the same cycle.
- Response in WAIT: push {fetch address of that request, mem_rdata}.
  - Next state is WAIT if a new request is accepted in the same cycle, else IDLE.
- Response in DISCARD: data is dropped.
  - Next state is WAIT if a new request is accepted without redirect, else IDLE (or DISCARD when a new request is accepted with redirect).
- Pop: instr_valid && decode_ready advances the read pointer.
- Redirect (highest priority):
  - count←0, pointers←0, fetch_pc←{redirect_pc[31:2],2'b00}.
  - Same-cycle pop and push are suppressed.
  - State WAIT→DISCARD; a request accepted in the same cycle also becomes DISCARD.
  - IDLE stays IDLE unless a request is accepted.
- A push and a pop in the same cycle leave count unchanged. The credit condition guarantees a push never overflows.
- The PC of the outstanding request is held in a dedicated register (req_pc) captured on accept.
- Reset values:
  - mem_req=0 during reset; mem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0, count=0, state=IDLE, fetch_pc=RESET_PC.
  - Fetching starts on the first clock edge after rst deasserts.

## Timing
- mem_req rises combinationally in the first cycle after reset release.
- Fetch-to-decode latency is measured from acceptance at cycle N, with the response at N+k:
  - with bypass, the entry is visible at cycle N+k;
  - without bypass, at N+k+1.
- Redirect at cycle R:
  - instr_valid=0 from R+1;
  - the new-target request is issued at R+1 if the state is IDLE, or on the cycle the discarded response arrives.
- Sustained throughput is 1 instruction/cycle when mem_ready=1, k=1 and decode_ready=1.
- Reset asserted mid-operation clears everything immediately and asynchronously. A response to a pre-reset request must not arrive after reset release (memory-side requirement).

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - when the FIFO is empty, a kept response drives instr/instr_pc/instr_valid combinationally in the same cycle;
  - if decode_ready=1 the instruction is consumed without being written; otherwise it is written.
  - redirect still masks it.
- Not defined: instr_valid is driven only from FIFO contents, so every instruction spends ≥1 cycle in the FIFO.

## Test plan
- Reset release with mem_ready=1, k=1 and 0x00000013 returned for every word → mem_addr sequence 0,4,8,…; instr_pc follows the same sequence one-per-cycle (first valid one cycle later without bypass).
- decode_ready=0 held 10 cycles → count reaches DEPTH=4 and mem_req stays 0. Releasing it → 4 pops at PCs 0,4,8,C, then fetching resumes at 0x10.
- Outstanding request at 0x8 with redirect to 0x103 in the same cycle → the 0x8 response is dropped; the next mem_addr is 0x100; the first instr_pc after the redirect is 0x100.
- Redirect in the same cycle as mem_rvalid and a pop → nothing pushed; instr_valid=0 the next cycle; count=0.
- fetch_pc=0xFFFF_FFFC → the next request address is 0x0000_0000.
- rst pulsed low for 1 cycle while count=3 → outputs return to their reset values at once, and fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bus bundle for fetch_queue: instruction-memory request/response, decode handshake and redirect.
// master = the fetch queue itself, slave = the surrounding core/memory.
interface fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;

    modport master (
        input  redirect, redirect_pc, mem_ready, mem_rvalid, mem_rdata, decode_ready,
        output mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_ready, mem_rvalid, mem_rdata, decode_ready,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential word fetches, one outstanding request, DEPTH-entry {pc, instr} FIFO.
// Optional macro FETCH_QUEUE_BYPASS_EN lets a kept response reach decode in its arrival cycle when the FIFO is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = PW + 2;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_WAIT    = 2'b01;
    localparam logic [1:0] ST_DISCARD = 2'b10;

    localparam logic [UW-1:0] DEPTH_W = UW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_next_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic [UW-1:0] used_s;
    logic          credit_s;
    logic          mem_req_s;
    logic          accept_s;
    logic          resp_keep_s;
    logic          fifo_valid_s;
    logic          bypass_s;
    logic          push_s;
    logic          pop_s;
    logic          instr_valid_s;
    logic [31:0]   instr_s;
    logic [31:0]   instr_pc_s;

    // Request credit, handshake qualification and push/pop decisions
    always_comb begin
        used_s       = {1'b0, count_r} + {{(UW-1){1'b0}}, (state_r == ST_WAIT)};
        credit_s     = (used_s < DEPTH_W);
        // Gated by rst so the request is low while reset is held
        mem_req_s    = rst && credit_s && ((state_r == ST_IDLE) || bus.mem_rvalid);
        accept_s     = mem_req_s && bus.mem_ready;
        resp_keep_s  = bus.mem_rvalid && (state_r == ST_WAIT) && !bus.redirect;
        fifo_valid_s = (count_r != {CW{1'b0}});
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s     = resp_keep_s && !fifo_valid_s;
`else
        bypass_s     = 1'b0;
`endif
        push_s       = resp_keep_s && !(bypass_s && bus.decode_ready);
        pop_s        = fifo_valid_s && bus.decode_ready && !bus.redirect;
    end

    // Decode-side view: FIFO head first, bypassed response only when the FIFO is empty
    always_comb begin
        if (fifo_valid_s) begin
            instr_valid_s = 1'b1;
            instr_s       = instr_mem_r[rd_ptr_r];
            instr_pc_s    = pc_mem_r[rd_ptr_r];
        end else if (bypass_s) begin
            instr_valid_s = 1'b1;
            instr_s       = bus.mem_rdata;
            instr_pc_s    = req_pc_r;
        end else begin
            instr_valid_s = 1'b0;
            instr_s       = 32'h0000_0000;
            instr_pc_s    = 32'h0000_0000;
        end
    end

    // Outstanding-request tracking: a redirect turns any in-flight or newly accepted request into DISCARD
    always_comb begin
        if (accept_s) begin
            state_next_s = bus.redirect ? ST_DISCARD : ST_WAIT;
        end else if ((state_r != ST_IDLE) && !bus.mem_rvalid) begin
            state_next_s = ((state_r == ST_WAIT) && !bus.redirect) ? ST_WAIT : ST_DISCARD;
        end else begin
            state_next_s = ST_IDLE;
        end
    end

    // Request state, next fetch address and PC of the outstanding request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= align_word(RESET_PC);
            req_pc_r   <= align_word(RESET_PC);
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                req_pc_r <= fetch_pc_r;
            end
            if (bus.redirect) begin
                fetch_pc_r <= align_word(bus.redirect_pc);
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (bus.redirect) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    // FIFO storage; contents are only observed through count_r, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= req_pc_r;
            instr_mem_r[wr_ptr_r] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req     = mem_req_s;
    assign bus.mem_addr    = fetch_pc_r;
    assign bus.instr_valid = instr_valid_s;
    assign bus.instr       = instr_s;
    assign bus.instr_pc    = instr_pc_s;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a memory model answers requests, a program-order scoreboard
// predicts the decode stream, and a separate monitor compares every consumed instruction.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if bus ();
    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] fetch_next;
    int tests = 0, fails = 0, cyc = 0, consumed = 0, base = 0;
    int ready_pct = 100, decode_pct = 100, resp_pct = 100, lat_max = 1, redir_pm = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = 32'h0000_0000;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_mem_req"}, {31'd0, bus.mem_req}, 32'd0);
        check32({tag, "_mem_addr"}, bus.mem_addr, RESET_PC);
        check32({tag, "_instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        check32({tag, "_instr"}, bus.instr, 32'd0);
        check32({tag, "_instr_pc"}, bus.instr_pc, 32'd0);
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(2))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(15));
            default: return 32'($urandom_range(255));
        endcase
    endfunction

    // One clock cycle of stimulus plus the memory model
    task automatic step();
        logic        redir;
        logic [31:0] tgt;
        pend_t       p;
        @(negedge clk);
        cyc++;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc && $urandom_range(99) < resp_pct) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = instr_of(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
        bus.mem_ready    = ($urandom_range(99) < ready_pct);
        bus.decode_ready = ($urandom_range(99) < decode_pct);
        redir = force_redir || (redir_pm > 0 && $urandom_range(999) < redir_pm);
        tgt   = force_redir ? force_target : pick_target();
        force_redir = 1'b0;
        bus.redirect    = redir;
        bus.redirect_pc = redir ? tgt : $urandom;
        if (redir) begin
            exp_q.delete();
            exp_pc = {tgt[31:2], 2'b00};
        end
        top_up();
        #1;
        if (bus.mem_req && bus.mem_ready) begin
            check32("fetch_addr", bus.mem_addr, fetch_next);
            check32("one_outstanding", pend_q.size(), 32'd0);
            p.addr = bus.mem_addr;
            p.due  = cyc + $urandom_range(lat_max - 1) + 1;
            pend_q.push_back(p);
            fetch_next = fetch_next + 32'd4;
        end
        if (redir) begin
            fetch_next = {tgt[31:2], 2'b00};
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        bus.redirect     = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.decode_ready = 1'b0;
        pend_q.delete();
        exp_q.delete();
        exp_pc     = RESET_PC;
        fetch_next = RESET_PC;
        top_up();
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        cyc++;
        rst = 1'b1;
    endtask

    // Monitor: compares each consumed instruction against the scoreboard
    initial begin : monitor
        logic        prev_flush;
        logic [31:0] e;
        prev_flush = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (!bus.instr_valid) begin
                check32("idle_instr", bus.instr, 32'd0);
                check32("idle_instr_pc", bus.instr_pc, 32'd0);
            end
            if (prev_flush && rst) begin
                check32("valid_after_flush", {31'd0, bus.instr_valid}, 32'd0);
            end
            if (rst && bus.instr_valid && bus.decode_ready && !bus.redirect) begin
                consumed++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: got pc %08h expected none", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check32("instr_pc", bus.instr_pc, e);
                    check32("instr", bus.instr, instr_of(e));
                end
            end
            prev_flush = bus.redirect || !rst;
        end
    end

    initial begin
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'd0;
        bus.mem_ready    = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = 32'd0;
        bus.decode_ready = 1'b0;
        exp_pc     = RESET_PC;
        fetch_next = RESET_PC;
        top_up();
        #1 rst = 1'b0;
        #2;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Streaming: ready=1, one-cycle latency, decode always ready
        base = consumed;
        repeat (20) begin
            step();
            check32("stream_req", {31'd0, bus.mem_req}, 32'd1);
        end
        tests++;
        if (consumed - base < 16) begin
            fails++;
            $display("FAIL stream_throughput: got %0d consumed expected >= 16", consumed - base);
        end

        // Decode stall fills the queue and stops requests
        decode_pct = 0;
        repeat (10) step();
        check32("full_no_req", {31'd0, bus.mem_req}, 32'd0);
        check32("full_valid", {31'd0, bus.instr_valid}, 32'd1);
        decode_pct = 100;
        repeat (10) step();

        // Redirect with an outstanding request, then a wrap-around target
        lat_max = 3;
        repeat (4) step();
        force_redir  = 1'b1;
        force_target = 32'h0000_0103;
        repeat (12) step();
        force_redir  = 1'b1;
        force_target = 32'hFFFF_FFF4;
        repeat (12) step();

        // Reset pulse with a partly full queue
        lat_max    = 1;
        decode_pct = 0;
        repeat (4) step();
        reset_pulse();
        decode_pct = 100;
        base = consumed;
        repeat (12) step();
        tests++;
        if (consumed - base < 8) begin
            fails++;
            $display("FAIL restart_after_reset: got %0d consumed expected >= 8", consumed - base);
        end

        // Randomized operation
        base = consumed;
        for (int blk = 0; blk < 30; blk++) begin
            ready_pct  = $urandom_range(100, 20);
            decode_pct = $urandom_range(100, 10);
            resp_pct   = $urandom_range(100, 30);
            lat_max    = $urandom_range(4, 1);
            redir_pm   = $urandom_range(60, 0);
            if (blk == 15) reset_pulse();
            repeat (100) step();
        end
        ready_pct  = 100;
        decode_pct = 100;
        resp_pct   = 100;
        redir_pm   = 0;
        repeat (20) step();
        tests++;
        if (consumed - base < 300) begin
            fails++;
            $display("FAIL random_progress: got %0d consumed expected >= 300", consumed - base);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
